sha256_msg_sequencer: RTL and testbench

Front-end controller for the byte-addressed SHA-256 core. It accepts a message byte stream, applies FIPS 180-4 single-block padding, and writes all 64 W-memory bytes into the core. It then starts the core, waits for its completion interrupt, reads back the 32-byte digest, and re-arms the core. It sits between the system stream fabric and the core register port, and is the only master of that port.

---
 rtl/sha256_pkg.sv | 31 +++
 rtl/sha256_pad_gen.sv | 26 ++
 rtl/sha256_msg_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_sha256_msg_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message sequencer.
// Core register map, sequencer states and error codes.
package sha256_pkg;

   localparam logic [6:0] W_BASE       = 7'd0;
   localparam logic [6:0] W_END        = 7'd63;
   localparam logic [6:0] STATUS_REG   = 7'd65;
   localparam logic [6:0] DIGEST_START = 7'd70;
   localparam logic [6:0] DIGEST_END   = 7'd101;

   localparam logic [7:0] PAD_MARK  = 8'h80;
   localparam logic [7:0] STAT_GO   = 8'h01;
   localparam logic [7:0] STAT_IDLE = 8'h00;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LONG = 2'b01;
   localparam logic [1:0] ERR_WD   = 2'b10;

   typedef enum logic [3:0] {
      CRST,
      IDLE,
      LOAD,
      DRAIN,
      PAD,
      START,
      WAIT,
      READ,
      CLEAR
   } state_e;

endpackage

// File: rtl/sha256_pad_gen.sv
// Single-block padding byte generator.
// Maps the block byte index and message length to the pad byte.
module sha256_pad_gen
   import sha256_pkg::*;
(
   input  logic [5:0] idx_i,
   input  logic [5:0] len_i,
   output logic [7:0] byte_o
);

   logic [15:0] bits;

   assign bits = {7'd0, len_i, 3'd0};

   // 0x80 right after the message, bit length in the last two bytes
   always_comb begin
      byte_o = 8'h00;
      unique case (1'b1)
         (idx_i == len_i): byte_o = PAD_MARK;
         (idx_i == 6'd62): byte_o = bits[15:8];
         (idx_i == 6'd63): byte_o = bits[7:0];
         default:          byte_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Front-end sequencer for the byte-addressed SHA-256 core.
// Loads and pads one block, runs the core, reads back the digest.
module sha256_msg_sequencer
   import sha256_pkg::*;
#(
   parameter int unsigned MAX_MSG_BYTES   = 55,
   parameter int unsigned WD_CYCLES       = 63,
   parameter int unsigned CORE_RST_CYCLES = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [7:0]   s_data,
   input  logic         s_valid,
   input  logic         s_last,
   output logic         s_ready,
   input  logic         s_empty,
   output logic         o_core_rst_n,
   output logic [6:0]   o_core_addr,
   output logic [7:0]   o_core_data8,
   output logic         o_core_we,
   input  logic         i_core_irq,
   input  logic [7:0]   i_core_data8,
   output logic [255:0] o_digest,
   output logic         o_digest_valid,
   output logic         o_busy,
   output logic         o_err,
   output logic [1:0]   o_err_code
);

   localparam logic [5:0] MAX_N    = 6'(MAX_MSG_BYTES);
   localparam logic [5:0] WD_LAST  = 6'(WD_CYCLES - 1);
   localparam logic [5:0] RST_LAST = 6'(CORE_RST_CYCLES - 1);

   state_e         state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [5:0]     step_q, step_d;
   logic           crst_n_q;
   logic [6:0]     addr_q, addr_d;
   logic [7:0]     data_q, data_d;
   logic           we_q, we_d;
   logic [255:0]   shift_q, shift_d;
   logic [255:0]   digest_q, digest_d;
   logic           dv_q, dv_d;
   logic           err_q, err_d;
   logic [1:0]     code_q, code_d;
   logic [7:0]     pad_byte;

   sha256_pad_gen u_pad (
      .idx_i  (step_q),
      .len_i  (cnt_q),
      .byte_o (pad_byte)
   );

   assign s_ready = (state_q == IDLE) ||
                    (state_q == LOAD) ||
                    (state_q == DRAIN);
   assign o_busy  = (state_q != IDLE);

   assign o_core_rst_n   = crst_n_q;
   assign o_core_addr    = addr_q;
   assign o_core_data8   = data_q;
   assign o_core_we      = we_q;
   assign o_digest       = digest_q;
   assign o_digest_valid = dv_q;
   assign o_err          = err_q;
   assign o_err_code     = code_q;

   // State and registered core-port outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= CRST;
         cnt_q    <= '0;
         step_q   <= '0;
         crst_n_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         we_q     <= 1'b0;
         shift_q  <= '0;
         digest_q <= '0;
         dv_q     <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         // lags CRST by one cycle so the CLEAR write lands
         // while the core is still out of reset
         crst_n_q <= (state_q != CRST);
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_q     <= we_d;
         shift_q  <= shift_d;
         digest_q <= digest_d;
         dv_q     <= dv_d;
         err_q    <= err_d;
         code_q   <= code_d;
      end
   end

   // Next-state and core-port command logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      step_d   = step_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_d     = 1'b0;
      shift_d  = shift_q;
      digest_d = digest_q;
      dv_d     = 1'b0;
      err_d    = 1'b0;
      code_d   = code_q;
      unique case (state_q)
         CRST: begin
            cnt_d = '0;
            if (step_q == RST_LAST) begin
               step_d  = '0;
               state_d = IDLE;
            end else begin
               step_d = step_q + 6'd1;
            end
         end
         IDLE: begin
            if (s_valid) begin
               addr_d  = W_END;
               data_d  = s_data;
               we_d    = 1'b1;
               cnt_d   = 6'd1;
               step_d  = 6'd1;
               code_d  = ERR_NONE;
               state_d = s_last ? PAD : LOAD;
            end else if (s_empty) begin
               cnt_d   = '0;
               step_d  = '0;
               code_d  = ERR_NONE;
               state_d = PAD;
            end
         end
         LOAD: begin
            if (s_valid) begin
               if (cnt_q == MAX_N) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LONG;
                  step_d  = '0;
                  state_d = s_last ? CRST : DRAIN;
               end else begin
                  addr_d = W_END - {1'b0, cnt_q};
                  data_d = s_data;
                  we_d   = 1'b1;
                  cnt_d  = cnt_q + 6'd1;
                  if (s_last) begin
                     step_d  = cnt_q + 6'd1;
                     state_d = PAD;
                  end
               end
            end
         end
         DRAIN: begin
            if (s_valid && s_last) begin
               step_d  = '0;
               state_d = CRST;
            end
         end
         PAD: begin
            addr_d = W_END - {1'b0, step_q};
            data_d = pad_byte;
            we_d   = 1'b1;
            if (step_q == 6'd63) begin
               step_d  = '0;
               state_d = START;
            end else begin
               step_d = step_q + 6'd1;
            end
         end
         START: begin
            addr_d  = STATUS_REG;
            data_d  = STAT_GO;
            we_d    = 1'b1;
            step_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (i_core_irq) begin
               addr_d  = DIGEST_END;
               step_d  = '0;
               state_d = READ;
            end else if (step_q == WD_LAST) begin
               err_d   = 1'b1;
               code_d  = ERR_WD;
               step_d  = '0;
               state_d = CRST;
            end else begin
               step_d = step_q + 6'd1;
            end
         end
         READ: begin
            // core data lags the presented address by one cycle
            if (step_q != 6'd0) begin
               shift_d = {shift_q[247:0], i_core_data8};
            end
            if (step_q < 6'd31) begin
               addr_d = DIGEST_END - 7'd1 - {1'b0, step_q};
            end
            if (step_q == 6'd32) begin
               step_d  = '0;
               state_d = CLEAR;
            end else begin
               step_d = step_q + 6'd1;
            end
         end
         CLEAR: begin
            addr_d   = STATUS_REG;
            data_d   = STAT_IDLE;
            we_d     = 1'b1;
            digest_d = shift_q;
            dv_d     = 1'b1;
            step_d   = '0;
            state_d  = CRST;
         end
         default: begin
            step_d  = '0;
            state_d = CRST;
         end
      endcase
   end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer with a behavioural core stub.
// Scoreboard queues hold expected digests and error codes.
module tb_sha256_msg_sequencer;

   localparam logic [255:0] D_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_EMPTY =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [31:0] H0 [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_last = 1'b0;
   logic         s_ready;
   logic         s_empty = 1'b0;
   logic         core_rst_n;
   logic [6:0]   core_addr;
   logic [7:0]   core_wdata;
   logic         core_we;
   logic         irq = 1'b0;
   logic [7:0]   core_rdata = '0;
   logic [255:0] digest;
   logic         digest_valid;
   logic         busy;
   logic         err;
   logic [1:0]   err_code;

   always #5 clk = ~clk;

   sha256_msg_sequencer dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_last         (s_last),
      .s_ready        (s_ready),
      .s_empty        (s_empty),
      .o_core_rst_n   (core_rst_n),
      .o_core_addr    (core_addr),
      .o_core_data8   (core_wdata),
      .o_core_we      (core_we),
      .i_core_irq     (irq),
      .i_core_data8   (core_rdata),
      .o_digest       (digest),
      .o_digest_valid (digest_valid),
      .o_busy         (busy),
      .o_err          (err),
      .o_err_code     (err_code)
   );

   int n_vec = 0;
   int n_bad = 0;
   int n_dig = 0;
   int n_errp = 0;
   int low_run = 0;
   int last_low = 0;
   logic [255:0] exp_dig [$];
   logic [1:0]   exp_err [$];

   function automatic logic [31:0] rotr(input logic [31:0] x,
                                        input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha256(input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3];
      e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
      for (int i = 0; i < 64; i++) begin
         s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
         t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
         s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
         t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {H0[0] + a, H0[1] + b, H0[2] + c, H0[3] + d,
              H0[4] + e, H0[5] + f, H0[6] + g, H0[7] + h};
   endfunction

   // Core stub: W memory, STATUS start/clear, irq, registered read mux
   logic [7:0]   wmem [0:63];
   logic         irq_en = 1'b1;
   logic         cbusy = 1'b0;
   logic [5:0]   ccnt = '0;
   logic [255:0] cdig = '0;

   function automatic logic [511:0] wblock();
      logic [511:0] blk;
      for (int k = 0; k < 64; k++) blk[511 - 8*k -: 8] = wmem[63 - k];
      return blk;
   endfunction

   always @(posedge clk) begin
      if (!core_rst_n) begin
         irq   <= 1'b0;
         cbusy <= 1'b0;
      end else begin
         if (core_we && core_addr < 7'd64) wmem[core_addr[5:0]] <= core_wdata;
         if (core_we && core_addr == 7'd65 && core_wdata == 8'h01) begin
            cbusy <= 1'b1;
            ccnt  <= '0;
            cdig  <= sha256(wblock());
         end else if (core_we && core_addr == 7'd65) begin
            irq <= 1'b0;
         end else if (cbusy) begin
            ccnt <= ccnt + 6'd1;
            if (ccnt == 6'd18) begin
               cbusy <= 1'b0;
               irq   <= irq_en;
            end
         end
      end
      if (core_addr >= 7'd70 && core_addr <= 7'd101)
         core_rdata <= cdig[255 - 8*(101 - int'(core_addr)) -: 8];
   end

   // Length of the most recent core-reset low period
   always @(negedge clk) begin
      if (!core_rst_n) low_run++;
      else begin
         if (low_run != 0) last_low = low_run;
         low_run = 0;
      end
   end

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic tmo(input string nm);
      n_vec++;
      n_bad++;
      $display("FAIL %s: got timeout required event", nm);
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports
   always @(negedge clk) begin
      if (rst_n) begin
         if (digest_valid) begin
            n_dig++;
            if (exp_dig.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL digest_extra: got %0h required none", digest);
            end else chk("digest", digest, exp_dig.pop_front());
         end
         if (err) begin
            n_errp++;
            if (exp_err.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL err_extra: got %0d required none", err_code);
            end else chk("err_code", 256'(err_code), 256'(exp_err.pop_front()));
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic last);
      int t;
      s_data = b; s_valid = 1'b1; s_last = last;
      t = 0;
      while (!s_ready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) tmo("send");
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_abc();
      send(8'h61, 1'b0);
      send(8'h62, 1'b0);
      send(8'h63, 1'b1);
   endtask

   task automatic send_empty();
      int t;
      s_empty = 1'b1;
      t = 0;
      while (!s_ready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) tmo("send_empty");
      @(negedge clk);
      s_empty = 1'b0;
   endtask

   task automatic wait_dig(input int target);
      int t;
      t = 0;
      while (n_dig < target && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) tmo("wait_digest");
   endtask

   task automatic wait_err(input int target);
      int t;
      t = 0;
      while (n_errp < target && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) tmo("wait_err");
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) tmo("wait_idle");
   endtask

   initial begin
      logic [511:0] blk;
      logic [255:0] d55;
      int c, d0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_core_rst_n", 256'(core_rst_n), 256'(0));
      chk("rst_we", 256'(core_we), 256'(0));
      chk("rst_addr", 256'(core_addr), 256'(0));
      chk("rst_data", 256'(core_wdata), 256'(0));
      chk("rst_digest", digest, 256'(0));
      chk("rst_dvalid", 256'(digest_valid), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      chk("rst_code", 256'(err_code), 256'(0));
      chk("rst_ready", 256'(s_ready), 256'(0));
      chk("rst_busy", 256'(busy), 256'(1));
      rst_n = 1'b1;

      // "abc"
      exp_dig.push_back(D_ABC);
      send_abc();
      wait_dig(1);
      chk("abc_addr0", 256'(wmem[0]), 256'(8'h18));
      chk("abc_addr60", 256'(wmem[60]), 256'(8'h80));
      chk("abc_addr63", 256'(wmem[63]), 256'(8'h61));
      chk("abc_addr61", 256'(wmem[61]), 256'(8'h63));

      // empty message
      exp_dig.push_back(D_EMPTY);
      send_empty();
      wait_dig(2);
      chk("empty_addr63", 256'(wmem[63]), 256'(8'h80));
      chk("empty_addr0", 256'(wmem[0]), 256'(8'h00));

      // back-to-back "abc" then empty
      exp_dig.push_back(D_ABC);
      exp_dig.push_back(D_EMPTY);
      send_abc();
      send_empty();
      wait_dig(4);
      chk("core_rst_low", 256'(last_low), 256'(2));

      // 55 bytes of 'a'
      blk = '0;
      for (int i = 0; i < 55; i++) blk[511 - 8*i -: 8] = 8'h61;
      blk[511 - 8*55 -: 8] = 8'h80;
      blk[15:0] = 16'd440;
      d55 = sha256(blk);
      exp_dig.push_back(d55);
      for (int i = 0; i < 55; i++) send(8'h61, (i == 54));
      wait_dig(5);
      chk("a55_addr8", 256'(wmem[8]), 256'(8'h80));
      chk("a55_addr1", 256'(wmem[1]), 256'(8'h01));
      chk("a55_addr0", 256'(wmem[0]), 256'(8'hb8));
      chk("a55_addr9", 256'(wmem[9]), 256'(8'h61));

      // 60 bytes: abort on the 56th, drain the rest
      exp_err.push_back(2'b01);
      d0 = n_dig;
      for (int i = 0; i < 60; i++) send(8'h62, (i == 59));
      wait_err(1);
      wait_idle();
      chk("long_no_digest", 256'(n_dig), 256'(d0));
      chk("long_byte56_dropped", 256'(wmem[8]), 256'(8'h80));
      chk("long_code_held", 256'(err_code), 256'(2'b01));
      chk("long_digest_held", digest, d55);

      // watchdog with irq never raised
      irq_en = 1'b0;
      exp_err.push_back(2'b10);
      send_abc();
      c = 0;
      while (!(core_we && core_addr == 7'd65 && core_wdata == 8'h01)
             && c < 300) begin
         @(negedge clk); c++;
      end
      if (c >= 300) tmo("wd_start");
      c = 0;
      while (!err && c < 200) begin @(negedge clk); c++; end
      chk("wd_wait_cycles", 256'(c), 256'(63));
      wait_err(2);
      wait_idle();
      chk("wd_code", 256'(err_code), 256'(2'b10));
      chk("wd_digest_held", digest, d55);
      irq_en = 1'b1;

      // reset in the middle of the digest read
      send_abc();
      chk("job_clears_code", 256'(err_code), 256'(0));
      c = 0;
      while (core_addr != 7'd90 && c < 300) begin @(negedge clk); c++; end
      if (c >= 300) tmo("read_reach");
      rst_n = 1'b0;
      #1;
      chk("mid_core_rst_n", 256'(core_rst_n), 256'(0));
      chk("mid_addr", 256'(core_addr), 256'(0));
      chk("mid_we", 256'(core_we), 256'(0));
      chk("mid_digest", digest, 256'(0));
      chk("mid_ready", 256'(s_ready), 256'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_dig.push_back(D_ABC);
      send_abc();
      wait_dig(n_dig + 1);
      chk("post_addr8", 256'(wmem[8]), 256'(8'h00));
      chk("sb_dig_empty", 256'(exp_dig.size()), 256'(0));
      chk("sb_err_empty", 256'(exp_err.size()), 256'(0));

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
